// File: rtl/key_search_controller.sv
// Brute-force key search: runs datapath per candidate key, then scans the
// decrypted D memory for lowercase/space bytes and reports the first hit.
// Ports: clk, reset (sync, active-high), search_start/search_done,
//   key_found, found_key, current_key, dp_key, datapath_start,
//   datapath_done, datapath_done_ack, d_mem_rd_addr, d_mem_data_read.
module key_search_controller #(
  parameter int KEY_WIDTH = 10,
  parameter int MSG_LEN   = 32,
  parameter int KEY_FIRST = 0,
  parameter int KEY_LAST  = 2**KEY_WIDTH-1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 search_start,
  output logic                 search_done,
  output logic                 key_found,
  output logic [KEY_WIDTH-1:0] found_key,
  output logic [KEY_WIDTH-1:0] current_key,
  output logic [KEY_WIDTH-1:0] dp_key,
  output logic                 datapath_start,
  input  logic                 datapath_done,
  output logic                 datapath_done_ack,
  output logic [4:0]           d_mem_rd_addr,
  input  logic [7:0]           d_mem_data_read
);

  localparam logic [KEY_WIDTH-1:0] KF = KEY_WIDTH'(KEY_FIRST);
  localparam logic [KEY_WIDTH-1:0] KL = KEY_WIDTH'(KEY_LAST);
  localparam logic [4:0] LAST_ADDR = 5'(MSG_LEN-1);

  typedef enum logic [2:0] {
    IDLE,
    START_DP,
    WAIT_DP,
    ACK,
    RD_WAIT,
    RD_CHECK,
    NEXT_KEY,
    DONE
  } state_t;

  state_t state;
  state_t state_n;

  logic [KEY_WIDTH-1:0] key_n;
  logic [KEY_WIDTH-1:0] found_key_n;
  logic                 key_found_n;
  logic [4:0]           addr_n;
  logic                 byte_ok;

  assign byte_ok =
    (d_mem_data_read >= 8'h61 &&
     d_mem_data_read <= 8'h7A) ||
    (d_mem_data_read == 8'h20);

  assign dp_key = current_key;

  always_comb begin
    state_n     = state;
    key_n       = current_key;
    found_key_n = found_key;
    key_found_n = key_found;
    addr_n      = d_mem_rd_addr;
    unique case (state)
      IDLE, DONE: begin
        if (search_start) begin
          state_n     = START_DP;
          key_n       = KF;
          found_key_n = '0;
          key_found_n = 1'b0;
        end
      end
      START_DP: state_n = WAIT_DP;
      WAIT_DP: begin
        if (datapath_done)
          state_n = ACK;
      end
      ACK: begin
        addr_n  = '0;
        state_n = RD_WAIT;
      end
      RD_WAIT: state_n = RD_CHECK;
      RD_CHECK: begin
        if (!byte_ok) begin
          state_n = NEXT_KEY;
        end else if (d_mem_rd_addr == LAST_ADDR) begin
          found_key_n = current_key;
          key_found_n = 1'b1;
          state_n     = DONE;
        end else begin
          addr_n  = d_mem_rd_addr + 5'd1;
          state_n = RD_WAIT;
        end
      end
      NEXT_KEY: begin
        // last-key test precedes the increment, so no wrap
        if (current_key == KL) begin
          found_key_n = '0;
          key_found_n = 1'b0;
          state_n     = DONE;
        end else begin
          key_n   = current_key + 1'b1;
          state_n = START_DP;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // pulses and done flag are registered from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      current_key       <= '0;
      found_key         <= '0;
      key_found         <= 1'b0;
      d_mem_rd_addr     <= '0;
      search_done       <= 1'b0;
      datapath_start    <= 1'b0;
      datapath_done_ack <= 1'b0;
    end else begin
      state             <= state_n;
      current_key       <= key_n;
      found_key         <= found_key_n;
      key_found         <= key_found_n;
      d_mem_rd_addr     <= addr_n;
      search_done       <= (state_n == DONE);
      datapath_start    <= (state_n == START_DP);
      datapath_done_ack <= (state_n == ACK);
    end
  end

endmodule

// File: tb/tb_key_search_controller.sv
// Bench for key_search_controller: datapath + D memory models, a
// reference search model feeding a scoreboard, and a decoupled monitor.
module tb_key_search_controller;

  localparam int KW  = 3;
  localparam int ML  = 32;
  localparam int KFI = 0;
  localparam int KLA = 7;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          search_start = 1'b0;
  logic          search_done;
  logic          key_found;
  logic [KW-1:0] found_key;
  logic [KW-1:0] current_key;
  logic [KW-1:0] dp_key;
  logic          datapath_start;
  logic          datapath_done;
  logic          datapath_done_ack;
  logic [4:0]    d_mem_rd_addr;
  logic [7:0]    d_mem_data_read;

  key_search_controller #(
    .KEY_WIDTH(KW),
    .MSG_LEN  (ML),
    .KEY_FIRST(KFI),
    .KEY_LAST (KLA)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .search_start     (search_start),
    .search_done      (search_done),
    .key_found        (key_found),
    .found_key        (found_key),
    .current_key      (current_key),
    .dp_key           (dp_key),
    .datapath_start   (datapath_start),
    .datapath_done    (datapath_done),
    .datapath_done_ack(datapath_done_ack),
    .d_mem_rd_addr    (d_mem_rd_addr),
    .d_mem_data_read  (d_mem_data_read)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(string nm, int act, int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // message produced by datapath for each key
  logic [7:0] tbl [0:7][0:31];

  // datapath model: done N cycles after start, held until ack
  int       lat_lo = 0;
  int       lat_hi = 4;
  int       dp_cnt;
  logic     dp_busy;
  logic [KW-1:0] mkey;

  always @(posedge clk) begin
    if (reset) begin
      dp_busy       <= 1'b0;
      dp_cnt        <= 0;
      datapath_done <= 1'b0;
      mkey          <= '0;
    end else begin
      if (datapath_start) begin
        dp_busy <= 1'b1;
        dp_cnt  <= $urandom_range(lat_hi, lat_lo);
        mkey    <= dp_key;
      end else if (dp_busy) begin
        if (dp_cnt == 0) begin
          dp_busy       <= 1'b0;
          datapath_done <= 1'b1;
        end else begin
          dp_cnt <= dp_cnt - 1;
        end
      end
      if (datapath_done && datapath_done_ack)
        datapath_done <= 1'b0;
    end
  end

  // D memory with one-cycle read latency
  always @(posedge clk)
    d_mem_data_read <= tbl[mkey][d_mem_rd_addr];

  // scoreboard entries: kind 0 = start pulse, 1 = search done
  typedef struct {
    int kind;
    int key;
    int found;
    int fkey;
    int gap;
  } ev_t;

  ev_t q[$];
  bit  sb_en = 1'b0;
  int  n_start = 0;
  int  n_ack = 0;

  function automatic bit ok_byte(logic [7:0] b);
    return (b >= 8'h61 && b <= 8'h7A) || b == 8'h20;
  endfunction

  // reference search; returns number of keys tried
  function automatic int build_expect();
    int prev_gap = -1;
    int tried = 0;
    for (int k = KFI; k <= KLA; k++) begin
      int nread = ML;
      q.push_back('{0, k, 0, 0, prev_gap});
      tried++;
      for (int a = 0; a < ML; a++)
        if (!ok_byte(tbl[k][a])) begin
          nread = a + 1;
          break;
        end
      if (nread == ML && ok_byte(tbl[k][ML-1])) begin
        q.push_back('{1, k, 1, k, 2*ML+1});
        return tried;
      end
      prev_gap = 2*nread + 2;
    end
    q.push_back('{1, KLA, 0, 0, prev_gap});
    return tried;
  endfunction

  // monitor
  initial begin
    int  since = 0;
    bit  prev_done = 1'b0;
    ev_t e;
    forever begin
      @(negedge clk);
      if (datapath_start) n_start++;
      if (datapath_done_ack) begin
        n_ack++;
        since = 0;
      end else begin
        since++;
      end
      if (sb_en && !reset) begin
        if (datapath_done_ack)
          chk("ack_without_done", datapath_done, 1);
        if (datapath_start) begin
          if (q.size() == 0) begin
            chk("start_unexpected", 1, 0);
          end else begin
            e = q.pop_front();
            chk("start_kind", 0, e.kind);
            chk("start_dp_key", dp_key, e.key);
            chk("start_cur_key", current_key, e.key);
            if (e.gap >= 0)
              chk("ack_to_start_gap", since, e.gap);
          end
        end
        if (search_done && !prev_done) begin
          if (q.size() == 0) begin
            chk("done_unexpected", 1, 0);
          end else begin
            e = q.pop_front();
            chk("done_kind", 1, e.kind);
            chk("key_found", key_found, e.found);
            chk("found_key", found_key, e.fkey);
            chk("done_cur_key", current_key, e.key);
            chk("ack_to_done_gap", since, e.gap);
          end
        end
      end
      prev_done = search_done;
    end
  end

  function automatic logic [7:0] rnd_ok();
    int r = $urandom_range(26, 0);
    return (r == 26) ? 8'h20 : 8'(8'h61 + r);
  endfunction

  function automatic logic [7:0] rnd_bad();
    logic [7:0] lst [8] =
      '{8'h60, 8'h7B, 8'h41, 8'h1F, 8'h21, 8'h00, 8'hFF, 8'h5A};
    return lst[$urandom_range(7, 0)];
  endfunction

  task automatic fill_valid(int k);
    for (int a = 0; a < ML; a++) tbl[k][a] = rnd_ok();
  endtask

  task automatic run_search(string nm, bit poke);
    int  tried;
    int  s0, a0, cyc;
    bit  was_done;
    tried = build_expect();
    s0 = n_start;
    a0 = n_ack;
    was_done = search_done;
    sb_en = 1'b1;
    @(posedge clk); #1 search_start = 1'b1;
    @(posedge clk); #1 search_start = 1'b0;
    @(negedge clk);
    if (was_done)
      chk({nm, "_restart_done_drop"}, search_done, 0);
    if (poke) begin
      @(posedge clk); #1 search_start = 1'b1;
      @(posedge clk); #1 search_start = 1'b0;
    end
    cyc = 0;
    while (!search_done && cyc < 4000) begin
      @(negedge clk);
      cyc++;
    end
    chk({nm, "_done_in_time"}, int'(cyc < 4000), 1);
    @(negedge clk);
    chk({nm, "_queue_drained"}, q.size(), 0);
    chk({nm, "_start_pulses"}, n_start - s0, tried);
    chk({nm, "_ack_pulses"}, n_ack - a0, tried);
    q.delete();
  endtask

  initial begin
    string s0;
    logic [7:0] outs;
    int  na, ns, cyc;
    for (int k = 0; k < 8; k++) fill_valid(k);

    // reset state
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_outputs",
        {search_done, key_found, found_key, current_key, dp_key,
         datapath_start, datapath_done_ack, d_mem_rd_addr}, 0);

    // reset while waiting on datapath
    lat_lo = 20;
    lat_hi = 20;
    @(posedge clk); #1 search_start = 1'b1;
    @(posedge clk); #1 search_start = 1'b0;
    cyc = 0;
    while (!datapath_start && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst_first_start_seen", datapath_start, 1);
    na = n_ack;
    @(posedge clk);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_outputs",
        {search_done, key_found, found_key, current_key, dp_key,
         datapath_start, datapath_done_ack, d_mem_rd_addr}, 0);
    @(posedge clk); #1 reset = 1'b0;
    ns = n_start;
    repeat (40) @(negedge clk);
    chk("rst_no_ack", n_ack, na);
    chk("rst_stays_idle", n_start, ns);
    chk("rst_idle_done", search_done, 0);
    lat_lo = 0;
    lat_hi = 4;

    // key 0 gives plain text
    s0 = "the quick brown fox jumps over a";
    for (int a = 0; a < ML; a++) tbl[0][a] = s0[a];
    run_search("key0", 1'b0);

    // only key 5 gives a valid message; start in WAIT_DP is ignored
    for (int k = 0; k < 8; k++) fill_valid(k);
    for (int k = 0; k < 5; k++)
      tbl[k][$urandom_range(ML-1, 0)] = rnd_bad();
    run_search("key5", 1'b1);

    // no key valid: final byte just above 'z'
    for (int k = 0; k < 8; k++) begin
      fill_valid(k);
      tbl[k][ML-1] = 8'h7B;
    end
    run_search("nokey", 1'b0);

    // character boundaries
    for (int k = 0; k < 8; k++) fill_valid(k);
    tbl[0][0]  = 8'h60;
    tbl[1][7]  = 8'h7B;
    tbl[2][19] = 8'h41;
    tbl[3][0]  = 8'h61;
    tbl[3][1]  = 8'h7A;
    tbl[3][30] = 8'h20;
    tbl[3][31] = 8'h7A;
    run_search("bounds", 1'b1);

    // randomized searches, each restarted from DONE
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 8; k++) begin
        fill_valid(k);
        if ($urandom_range(3, 0) != 0)
          tbl[k][$urandom_range(ML-1, 0)] = rnd_bad();
      end
      run_search("rand", r[0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
